// File: rtl/frame_buffer.sv
// Triple-buffered frame store between the ray marcher and the display.
// Completed frames are promoted to the display only at vertical-blank start.
module frame_buffer #(
   parameter int DISPLAY_WIDTH  = 320,
   parameter int DISPLAY_HEIGHT = 240,
   parameter int H_BITS         = 9,
   parameter int V_BITS         = 8,
   parameter int COLOR_BITS     = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [H_BITS-1:0]     wr_hcount_in,
   input  logic [V_BITS-1:0]     wr_vcount_in,
   input  logic [COLOR_BITS-1:0] wr_color_in,
   input  logic                  wr_valid_in,
   input  logic                  new_frame_in,
   input  logic [H_BITS-1:0]     rd_hcount_in,
   input  logic [V_BITS-1:0]     rd_vcount_in,
   output logic [COLOR_BITS-1:0] color_out,
   output logic                  color_valid_out,
   output logic [1:0]            display_bank_out,
   output logic [7:0]            drop_count_out
);

   localparam int FRAME = DISPLAY_WIDTH * DISPLAY_HEIGHT;
   localparam int DEPTH = 3 * FRAME;
   localparam int AW    = $clog2(DEPTH);

   logic [1:0]            write_bank;
   logic [1:0]            ready_bank;
   logic [1:0]            display_bank;
   logic                  fresh;
   logic                  new_frame_q;
   logic                  frame_evt;
   logic                  vblank_evt;
   logic                  wr_en;
   logic                  rd_in_range;
   logic [AW-1:0]         wr_addr;
   logic [AW-1:0]         rd_addr;
   logic [AW-1:0]         rd_addr_q;
   logic                  rd_in_q;
   logic                  rd_in_qq;
   logic [COLOR_BITS-1:0] rd_data_q;
   logic [7:0]            drop_inc;
   logic [COLOR_BITS-1:0] mem [DEPTH];

   function automatic logic [AW-1:0] pix_addr(
      input logic [1:0]        bank,
      input logic [V_BITS-1:0] v,
      input logic [H_BITS-1:0] h
   );
      return AW'(bank) * AW'(FRAME) + AW'(v) * AW'(DISPLAY_WIDTH) + AW'(h);
   endfunction

   assign frame_evt  = new_frame_in & ~new_frame_q;
   assign vblank_evt = (rd_vcount_in == V_BITS'(DISPLAY_HEIGHT))
                     && (rd_hcount_in == '0);

   assign wr_en = wr_valid_in
                && (wr_hcount_in < H_BITS'(DISPLAY_WIDTH))
                && (wr_vcount_in < V_BITS'(DISPLAY_HEIGHT));

   assign rd_in_range = (rd_hcount_in < H_BITS'(DISPLAY_WIDTH))
                      && (rd_vcount_in < V_BITS'(DISPLAY_HEIGHT));

   assign wr_addr  = pix_addr(write_bank, wr_vcount_in, wr_hcount_in);
   assign rd_addr  = pix_addr(display_bank, rd_vcount_in, rd_hcount_in);
   assign drop_inc = (drop_count_out == 8'hFF) ? 8'hFF : drop_count_out + 8'd1;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         write_bank     <= 2'd0;
         ready_bank     <= 2'd1;
         display_bank   <= 2'd2;
         fresh          <= 1'b0;
         new_frame_q    <= 1'b0;
         drop_count_out <= 8'd0;
      end else begin
         new_frame_q <= new_frame_in;
         unique case (1'b1)
            // Finished frame goes straight to the display; the stale ready one is lost.
            frame_evt && vblank_evt: begin
               display_bank <= write_bank;
               write_bank   <= display_bank;
               fresh        <= 1'b0;
               if (fresh) drop_count_out <= drop_inc;
            end
            frame_evt && !vblank_evt: begin
               ready_bank <= write_bank;
               write_bank <= ready_bank;
               fresh      <= 1'b1;
               if (fresh) drop_count_out <= drop_inc;
            end
            vblank_evt && !frame_evt && fresh: begin
               display_bank <= ready_bank;
               ready_bank   <= display_bank;
               fresh        <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_addr_q <= '0;
         rd_in_q   <= 1'b0;
         rd_in_qq  <= 1'b0;
      end else begin
         rd_addr_q <= rd_addr;
         rd_in_q   <= rd_in_range;
         rd_in_qq  <= rd_in_q;
      end
   end

   // Memory port kept reset-free so it maps onto block RAM.
   always_ff @(posedge clk_in) begin
      if (wr_en) mem[wr_addr] <= wr_color_in;
      rd_data_q <= mem[rd_addr_q];
   end

   assign color_out        = rd_in_qq ? rd_data_q : '0;
   assign color_valid_out  = rd_in_qq;
   assign display_bank_out = display_bank;

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: reads are queued with their expected
// colour and retired two clocks later; bank handoff checked per scenario.
module tb_frame_buffer;

   localparam int W = 320;
   localparam int H = 240;
   localparam int F = W * H;

   typedef struct {
      int         h;
      int         v;
      logic       vld;
      logic       known;
      logic [3:0] col;
   } rd_exp_t;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic [8:0] wr_hcount_in;
   logic [7:0] wr_vcount_in;
   logic [3:0] wr_color_in;
   logic       wr_valid_in;
   logic       new_frame_in;
   logic [8:0] rd_hcount_in;
   logic [7:0] rd_vcount_in;
   logic [3:0] color_out;
   logic       color_valid_out;
   logic [1:0] display_bank_out;
   logic [7:0] drop_count_out;

   rd_exp_t    q[$];
   logic [3:0] mdl [int];
   int         exp_disp;
   int         exp_wbank;
   int         n_checks;
   int         n_fail;

   frame_buffer dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .wr_hcount_in     (wr_hcount_in),
      .wr_vcount_in     (wr_vcount_in),
      .wr_color_in      (wr_color_in),
      .wr_valid_in      (wr_valid_in),
      .new_frame_in     (new_frame_in),
      .rd_hcount_in     (rd_hcount_in),
      .rd_vcount_in     (rd_vcount_in),
      .color_out        (color_out),
      .color_valid_out  (color_valid_out),
      .display_bank_out (display_bank_out),
      .drop_count_out   (drop_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic rd(input int h, input int v);
      rd_hcount_in = 9'(h);
      rd_vcount_in = 8'(v);
   endtask

   task automatic idle();
      rd(400, 250);
   endtask

   task automatic wr(input int h, input int v, input int c);
      wr_hcount_in = 9'(h);
      wr_vcount_in = 8'(v);
      wr_color_in  = 4'(c);
      wr_valid_in  = 1'b1;
   endtask

   // One clock: queue the expected read result, update the memory model,
   // then retire the read issued two clocks earlier.
   task automatic cyc();
      rd_exp_t e;
      rd_exp_t got;
      int      a;
      int      wh;
      int      wv;
      e.h     = int'(rd_hcount_in);
      e.v     = int'(rd_vcount_in);
      e.vld   = (e.h < W) && (e.v < H);
      a       = exp_disp * F + e.v * W + e.h;
      e.known = e.vld && mdl.exists(a);
      e.col   = e.known ? mdl[a] : 4'h0;
      q.push_back(e);
      wh = int'(wr_hcount_in);
      wv = int'(wr_vcount_in);
      if (wr_valid_in && wh < W && wv < H)
         mdl[exp_wbank * F + wv * W + wh] = wr_color_in;
      @(posedge clk_in);
      @(negedge clk_in);
      wr_valid_in = 1'b0;
      if (q.size() >= 2) begin
         got = q.pop_front();
         n_checks++;
         if (color_valid_out !== got.vld) begin
            n_fail++;
            $display("FAIL rd_valid (%0d,%0d): got %b want %b",
                     got.h, got.v, color_valid_out, got.vld);
         end
         if (got.known || !got.vld) begin
            n_checks++;
            if (color_out !== got.col) begin
               n_fail++;
               $display("FAIL rd_color (%0d,%0d): got %h want %h",
                        got.h, got.v, color_out, got.col);
            end
         end
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (display_bank_out !== 2'd2) begin
         n_fail++;
         $display("FAIL reset_disp: got %0d want 2", display_bank_out);
      end
      n_checks++;
      if (drop_count_out !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_drop: got %0d want 0", drop_count_out);
      end
      n_checks++;
      if (color_out !== 4'h0 || color_valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_color: got %h/%b want 0/0", color_out, color_valid_out);
      end
      idle(); cyc();
      for (int i = 0; i < 3; i++) begin
         rd(i, 0); cyc();
      end
      idle(); cyc(); cyc();
   endtask

   task automatic test_write_swap();
      wr(5, 7, 'hA); cyc();
      new_frame_in = 1'b1;
      wr(6, 7, 'h5); cyc();
      exp_wbank = 1;
      cyc();
      new_frame_in = 1'b0; cyc();
      rd(0, 240); cyc();
      exp_disp = 0;
      n_checks++;
      if (display_bank_out !== 2'd0) begin
         n_fail++;
         $display("FAIL swap_disp: got %0d want 0", display_bank_out);
      end
      rd(5, 7); cyc();
      rd(6, 7); cyc();
      idle(); cyc(); cyc();
   endtask

   task automatic test_out_of_range();
      wr(0, 0, 'h3);       cyc();
      wr(0, 1, 'h4);       cyc();
      wr(W - 1, H - 1, 'h9); cyc();
      wr(W, 0, 'hF);       cyc();
      wr(0, H, 'hF);       cyc();
      wr(511, 255, 'hF);   cyc();
      new_frame_in = 1'b1; cyc();
      new_frame_in = 1'b0; cyc();
      exp_wbank = 2;
      rd(0, 240); cyc();
      exp_disp = 1;
      n_checks++;
      if (display_bank_out !== 2'd1) begin
         n_fail++;
         $display("FAIL oor_disp: got %0d want 1", display_bank_out);
      end
      rd(0, 0);         cyc();
      rd(0, 1);         cyc();
      rd(W - 1, H - 1); cyc();
      rd(W, 5);         cyc();
      rd(5, H);         cyc();
      idle(); cyc(); cyc();
   endtask

   task automatic test_drops();
      for (int i = 0; i < 3; i++) begin
         new_frame_in = 1'b1; cyc();
         new_frame_in = 1'b0; cyc();
      end
      exp_wbank = 0;
      n_checks++;
      if (drop_count_out !== 8'd2) begin
         n_fail++;
         $display("FAIL drops_cnt: got %0d want 2", drop_count_out);
      end
      n_checks++;
      if (display_bank_out !== 2'd1) begin
         n_fail++;
         $display("FAIL drops_disp: got %0d want 1", display_bank_out);
      end
      rd(0, 240); cyc();
      exp_disp = 2;
      n_checks++;
      if (display_bank_out !== 2'd2) begin
         n_fail++;
         $display("FAIL drops_fresh: got %0d want 2", display_bank_out);
      end
      idle(); cyc();
   endtask

   task automatic test_e_and_v();
      new_frame_in = 1'b1; cyc();
      new_frame_in = 1'b0; cyc();
      exp_wbank = 1;
      new_frame_in = 1'b1;
      rd(0, 240); cyc();
      exp_disp  = 1;
      exp_wbank = 2;
      n_checks++;
      if (display_bank_out !== 2'd1) begin
         n_fail++;
         $display("FAIL ev_disp: got %0d want 1", display_bank_out);
      end
      n_checks++;
      if (drop_count_out !== 8'd3) begin
         n_fail++;
         $display("FAIL ev_drop: got %0d want 3", drop_count_out);
      end
      new_frame_in = 1'b0;
      idle(); cyc();
      rd(0, 240); cyc();
      n_checks++;
      if (display_bank_out !== 2'd1) begin
         n_fail++;
         $display("FAIL ev_noswap: got %0d want 1", display_bank_out);
      end
      idle();
      wr(0, 0, 'hC); cyc();
      rd(0, 0); cyc();
      idle(); cyc(); cyc();
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 260; i++) begin
         new_frame_in = 1'b1; cyc();
         new_frame_in = 1'b0; cyc();
         if (i == 199) begin
            n_checks++;
            if (drop_count_out !== 8'd202) begin
               n_fail++;
               $display("FAIL sat_mid: got %0d want 202", drop_count_out);
            end
         end
      end
      n_checks++;
      if (drop_count_out !== 8'd255) begin
         n_fail++;
         $display("FAIL sat_cap: got %0d want 255", drop_count_out);
      end
      n_checks++;
      if (display_bank_out !== 2'd1) begin
         n_fail++;
         $display("FAIL sat_disp: got %0d want 1", display_bank_out);
      end
   endtask

   task automatic test_reset_mid();
      rd(0, 0); cyc(); cyc(); cyc();
      #2 rst_n_in = 1'b0;
      #1;
      n_checks++;
      if (color_out !== 4'h0 || color_valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_async_color: got %h/%b want 0/0", color_out, color_valid_out);
      end
      n_checks++;
      if (display_bank_out !== 2'd2 || drop_count_out !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_async_ptr: got %0d/%0d want 2/0",
                  display_bank_out, drop_count_out);
      end
      q.delete();
      @(negedge clk_in);
      @(negedge clk_in);
      rst_n_in  = 1'b1;
      exp_disp  = 2;
      exp_wbank = 0;
      rd(0, 240); cyc();
      n_checks++;
      if (display_bank_out !== 2'd2) begin
         n_fail++;
         $display("FAIL rst_noswap: got %0d want 2", display_bank_out);
      end
      n_checks++;
      if (drop_count_out !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_drop: got %0d want 0", drop_count_out);
      end
      rd(0, 0); cyc();
      idle(); cyc(); cyc();
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      exp_disp     = 2;
      exp_wbank    = 0;
      rst_n_in     = 1'b0;
      wr_hcount_in = '0;
      wr_vcount_in = '0;
      wr_color_in  = '0;
      wr_valid_in  = 1'b0;
      new_frame_in = 1'b0;
      idle();
      repeat (3) @(negedge clk_in);
      rst_n_in = 1'b1;
      test_reset();
      test_write_swap();
      test_out_of_range();
      test_drops();
      test_e_and_v();
      test_saturate();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
